// File: rtl/axis_pattern_gen_pkg.sv
// Shared types and helpers for the AXI-Stream pattern generator.
// Holds mode/state encodings and the pattern word step function.
package axis_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'd0,
        MODE_FIXED   = 2'd1,
        MODE_LFSR    = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Mode 3 is not a named mode and falls through to counter behaviour.
    function automatic logic [15:0] next_word(
        input logic [1:0]  mode,
        input logic [15:0] word
    );
        logic [15:0] w;
        w = word + 16'd1;
        case (mode)
            MODE_FIXED: w = word;
            MODE_LFSR:  w = (word >> 1) ^ (word[0] ? LFSR_TAPS : 16'h0000);
            default:    w = word + 16'd1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pattern_word_gen.sv
// 16-bit pattern word register: load from seed, step on each accepted beat.
// An all-zero LFSR seed would lock up, so it is forced to 1 on load.
module pattern_word_gen
    import axis_pattern_gen_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic [1:0]  mode,
    input  logic        advance,
    output logic [15:0] word
);

    logic [1:0] mode_r;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            word   <= 16'h0000;
            mode_r <= MODE_COUNTER;
        end else if (load) begin
            mode_r <= mode;
            if (mode == MODE_LFSR && seed == 16'h0000)
                word <= 16'h0001;
            else
                word <= seed;
        end else if (advance) begin
            word <= next_word(mode_r, word);
        end
    end

endmodule

// File: rtl/axis_pattern_gen.sv
// Packetised AXI-Stream test-pattern source for datapath bring-up.
// FSM, beat/gap/packet counters and config latch; word replicated across the bus.
module axis_pattern_gen
    import axis_pattern_gen_pkg::*;
#(
    parameter int DATA_W        = 512,
    parameter int STARTUP_DELAY = 200000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [1:0]        cfg_mode,
    input  logic [15:0]       cfg_seed,
    input  logic [15:0]       cfg_pkt_len,
    input  logic [31:0]       cfg_pkt_count,
    input  logic [15:0]       cfg_gap,
    output logic              busy,
    output logic [31:0]       pkts_sent,
    output logic [DATA_W-1:0] AXIS_TDATA,
    output logic              AXIS_TVALID,
    output logic              AXIS_TLAST,
    input  logic              AXIS_TREADY
);

    state_t      state;
    logic [31:0] dly;
    logic [15:0] len_r;
    logic [31:0] cnt_r;
    logic [15:0] gap_r;
    logic [15:0] beat;
    logic [15:0] gap_cnt;
    logic        stop_pend;
    logic [15:0] word;

    logic        start_ok;
    logic        accept;
    logic        done;
    logic [15:0] beat_nx;

    assign start_ok = (state == ST_IDLE) && cfg_start;
    assign accept   = AXIS_TVALID && AXIS_TREADY;
    assign beat_nx  = beat + 16'd1;
    assign done     = stop_pend || cfg_stop ||
                      (cnt_r != 32'd0 && (pkts_sent + 32'd1) == cnt_r);

    pattern_word_gen u_word (
        .clk     (clk),
        .resetn  (resetn),
        .load    (start_ok),
        .seed    (cfg_seed),
        .mode    (cfg_mode),
        .advance (accept),
        .word    (word)
    );

    assign AXIS_TDATA = {(DATA_W/16){word}};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_INIT;
            dly         <= 32'(STARTUP_DELAY);
            len_r       <= 16'd1;
            cnt_r       <= 32'd0;
            gap_r       <= 16'd0;
            beat        <= 16'd1;
            gap_cnt     <= 16'd0;
            stop_pend   <= 1'b0;
            busy        <= 1'b0;
            pkts_sent   <= 32'd0;
            AXIS_TVALID <= 1'b0;
            AXIS_TLAST  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (dly <= 32'd1)
                        state <= ST_IDLE;
                    else
                        dly <= dly - 32'd1;
                end
                ST_IDLE: begin
                    if (cfg_start) begin
                        len_r       <= (cfg_pkt_len == 16'd0) ? 16'd1 : cfg_pkt_len;
                        cnt_r       <= cfg_pkt_count;
                        gap_r       <= cfg_gap;
                        pkts_sent   <= 32'd0;
                        stop_pend   <= 1'b0;
                        busy        <= 1'b1;
                        beat        <= 16'd1;
                        AXIS_TVALID <= 1'b1;
                        AXIS_TLAST  <= (cfg_pkt_len <= 16'd1);
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (cfg_stop)
                        stop_pend <= 1'b1;
                    if (accept) begin
                        if (AXIS_TLAST) begin
                            pkts_sent <= pkts_sent + 32'd1;
                            beat      <= 16'd1;
                            if (done) begin
                                state       <= ST_IDLE;
                                busy        <= 1'b0;
                                AXIS_TVALID <= 1'b0;
                                AXIS_TLAST  <= 1'b0;
                            end else if (gap_r == 16'd0) begin
                                AXIS_TLAST <= (len_r == 16'd1);
                            end else begin
                                state       <= ST_GAP;
                                gap_cnt     <= gap_r;
                                AXIS_TVALID <= 1'b0;
                                AXIS_TLAST  <= 1'b0;
                            end
                        end else begin
                            beat       <= beat_nx;
                            AXIS_TLAST <= (beat_nx == len_r);
                        end
                    end
                end
                ST_GAP: begin
                    // A stop during the gap ends the run without another packet.
                    if (cfg_stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (gap_cnt <= 16'd1) begin
                        state       <= ST_SEND;
                        AXIS_TVALID <= 1'b1;
                        AXIS_TLAST  <= (len_r == 16'd1);
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed-vector bench for axis_pattern_gen (64-bit bus, short startup).
// Expected words, strobes and counts are hand-derived per scenario.
module tb_axis_pattern_gen;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cfg_start;
    logic          cfg_stop;
    logic [1:0]    cfg_mode;
    logic [15:0]   cfg_seed;
    logic [15:0]   cfg_pkt_len;
    logic [31:0]   cfg_pkt_count;
    logic [15:0]   cfg_gap;
    logic          busy;
    logic [31:0]   pkts_sent;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    axis_pattern_gen #(.DATA_W(DW), .STARTUP_DELAY(10)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_mode      (cfg_mode),
        .cfg_seed      (cfg_seed),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_pkt_count (cfg_pkt_count),
        .cfg_gap       (cfg_gap),
        .busy          (busy),
        .pkts_sent     (pkts_sent),
        .AXIS_TDATA    (tdata),
        .AXIS_TVALID   (tvalid),
        .AXIS_TLAST    (tlast),
        .AXIS_TREADY   (tready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rep(input logic [15:0] w);
        return {4{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] m, input logic [15:0] s, input logic [15:0] l,
                         input logic [31:0] c, input logic [15:0] g);
        cfg_mode      = m;
        cfg_seed      = s;
        cfg_pkt_len   = l;
        cfg_pkt_count = c;
        cfg_gap       = g;
        cfg_start     = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    logic [15:0] w2 [6];
    logic [15:0] w4 [3];
    logic [17:0] v3;
    logic [17:0] l3;

    initial begin
        w2 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
        w4 = '{16'h0001, 16'hB400, 16'h5A00};
        v3 = 18'b0_11111111_00_1111111;
        l3 = 18'b0_11000000_00_1100000;

        resetn = 1'b0;
        cfg_start = 1'b0;
        cfg_stop = 1'b0;
        cfg_mode = 2'd0;
        cfg_seed = 16'h0;
        cfg_pkt_len = 16'd1;
        cfg_pkt_count = 32'd0;
        cfg_gap = 16'd0;
        tready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(tvalid), 64'd0);
        chk("rst_last", 64'(tlast), 64'd0);
        chk("rst_data", tdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkts", 64'(pkts_sent), 64'd0);

        // startup gate: start at cycle 5 ignored, at cycle 12 taken
        resetn = 1'b1;
        tready = 1'b1;
        repeat (4) tick();
        start(2'd0, 16'hFFFE, 16'd3, 32'd2, 16'd0);
        chk("init_ign_valid", 64'(tvalid), 64'd0);
        chk("init_ign_busy", 64'(busy), 64'd0);
        repeat (6) tick();
        start(2'd0, 16'hFFFE, 16'd3, 32'd2, 16'd0);
        chk("start_busy", 64'(busy), 64'd1);

        // counter wrap across packets
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("cnt_valid%0d", i), 64'(tvalid), 64'd1);
            chk($sformatf("cnt_data%0d", i), tdata, rep(w2[i]));
            chk($sformatf("cnt_last%0d", i), 64'(tlast), 64'((i % 3) == 2));
            if (i == 3) chk("cnt_pkts_mid", 64'(pkts_sent), 64'd1);
            tick();
        end
        chk("cnt_end_busy", 64'(busy), 64'd0);
        chk("cnt_end_valid", 64'(tvalid), 64'd0);
        chk("cnt_end_pkts", 64'(pkts_sent), 64'd2);

        // fixed pattern, gap 2, tready toggling
        start(2'd1, 16'hA5A5, 16'd4, 32'd2, 16'd2);
        for (int t = 0; t < 18; t++) begin
            tready = (t % 2 == 0);
            chk($sformatf("fix_valid%0d", t), 64'(tvalid), 64'(v3[t]));
            chk($sformatf("fix_last%0d", t), 64'(tlast), 64'(l3[t]));
            if (v3[t]) chk($sformatf("fix_data%0d", t), tdata, rep(16'hA5A5));
            tick();
        end
        chk("fix_pkts", 64'(pkts_sent), 64'd2);
        chk("fix_busy", 64'(busy), 64'd0);

        // LFSR with zero seed
        tready = 1'b1;
        start(2'd2, 16'h0000, 16'd1, 32'd3, 16'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lfsr_data%0d", i), tdata, rep(w4[i]));
            chk($sformatf("lfsr_last%0d", i), 64'(tlast), 64'd1);
            tick();
        end
        chk("lfsr_busy", 64'(busy), 64'd0);
        chk("lfsr_pkts", 64'(pkts_sent), 64'd3);

        // unlimited run stopped at beat 3 of packet 2
        start(2'd0, 16'h0000, 16'd8, 32'd0, 16'd0);
        for (int t = 0; t < 16; t++) begin
            cfg_stop = (t == 10);
            chk($sformatf("stop_data%0d", t), tdata, rep(16'(t)));
            chk($sformatf("stop_last%0d", t), 64'(tlast), 64'((t % 8) == 7));
            chk($sformatf("stop_valid%0d", t), 64'(tvalid), 64'd1);
            tick();
        end
        cfg_stop = 1'b0;
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_valid", 64'(tvalid), 64'd0);
        chk("stop_pkts", 64'(pkts_sent), 64'd2);

        // reset mid-packet while stalled
        start(2'd0, 16'h0010, 16'd2, 32'd0, 16'd0);
        repeat (3) tick();
        tready = 1'b0;
        tick();
        chk("mid_valid", 64'(tvalid), 64'd1);
        chk("mid_pkts", 64'(pkts_sent), 64'd1);
        chk("mid_data", tdata, rep(16'h0013));
        resetn = 1'b0;
        tick();
        chk("rst2_valid", 64'(tvalid), 64'd0);
        chk("rst2_data", tdata, 64'd0);
        chk("rst2_pkts", 64'(pkts_sent), 64'd0);
        chk("rst2_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        tready = 1'b1;
        start(2'd1, 16'h1234, 16'd1, 32'd1, 16'd0);
        chk("rst2_ign", 64'(tvalid), 64'd0);
        repeat (9) tick();
        start(2'd1, 16'h1234, 16'd1, 32'd1, 16'd0);
        chk("rst2_take_valid", 64'(tvalid), 64'd1);
        chk("rst2_take_data", tdata, rep(16'h1234));
        tick();
        chk("rst2_take_pkts", 64'(pkts_sent), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
